udp_payload_streamer: RTL and testbench
=======================================

# udp_payload_streamer

Parametrised UDP payload source. It holds a byte payload in an internal buffer that the host writes. On `start` it emits one frame of `len` bytes over a valid/ready byte stream, with `out_last` marking the final byte. Optionally each frame is prefixed with a 16-bit big-endian sequence number. It sits in the Ethernet path ahead of the UDP/IP header inserter and replaces the fixed-message sender.

## Interface
Parameters:
- `DEPTH`, 64: payload buffer size in bytes; must be a power of two and ≥2.
- `AW`, $clog2(DEPTH): buffer address width.
- `LW`, $clog2(DEPTH)+1: width of `len`.
- `SEQ_EN`, 1: 1 prefixes two sequence bytes (MSB first); 0 emits the payload only.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  payload buffer write strobe.
- `wr_addr`  in  AW  payload buffer write address.
- `wr_data`  in  8  payload buffer write byte.
- `start`  in  1  frame request; sampled only when `busy`=0.
- `len`  in  LW  payload byte count, sampled with an accepted `start`.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  current beat is the last of the frame.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse after the last beat transfers.
- `seq_num`  out  16  sequence number of the next or current frame.

## Operation
- Reset value of every output is 0. The sequence counter resets to 0; buffer contents are undefined.
- Writes to the buffer:
  - Apply when `wr_en`=1 and `busy`=0.
  - Are ignored while `busy`=1, and also in the cycle a `start` is accepted, so the frame payload is frozen.
- `start` is accepted when `busy`=0 and `len`≠0. The block latches `len`, clamped to DEPTH if larger.
- `start` with `len`=0 is ignored: no frame, no `done`. `start` while `busy`=1 is ignored.
- States and transitions:
  - IDLE: `busy`=0, `out_valid`=0. Accepted `start` → SEQ_HI if SEQ_EN=1, otherwise → DATA.
  - SEQ_HI: `out_data`=`seq_num[15:8]`. On handshake → SEQ_LO.
  - SEQ_LO: `out_data`=`seq_num[7:0]`. On handshake → DATA.
  - DATA: `out_data`=buffer[rd_ptr], with rd_ptr starting at 0. On each handshake rd_ptr increments. `out_last`=1 when rd_ptr = latched_len−1. A handshake on the last beat → DONE.
  - DONE: one cycle. `done`=1, `busy`=0, `out_valid`=0. `seq_num` increments (modulo 2^16, 0xFFFF→0x0000). Then → IDLE.
- A handshake is `out_valid` & `out_ready` at a rising edge.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable. `out_valid` never drops before its handshake.
- `out_last` is 0 on sequence bytes. With `len`=1 and SEQ_EN=0, the first beat carries `out_last`=1.
- A frame always runs to completion; it cannot be aborted except by `rst`.
- `rst` mid-frame:
  - immediately clears `out_valid`, `out_last`, `busy` and `done`, and returns to IDLE;
  - `seq_num` returns to 0;
  - the downstream consumer must discard the partial frame.

## Timing
- `start` accepted at edge T: `busy`=1 and `out_valid`=1 with the first byte from edge T onward, visible in cycle T+1.
- With `out_ready` held at 1, a frame is N = `len` + 2·SEQ_EN beats on consecutive cycles.
- The last handshake at edge T+N is followed by `done`=1 during cycle T+N+1.
- The earliest next `start` is sampled at the DONE edge. Minimum frame-to-frame spacing is N+1 cycles.
- Each cycle of `out_ready`=0 stretches the frame by one cycle; bytes are never duplicated or skipped.
- `out_data` is registered, or read from the buffer through a registered rd_ptr. There is no combinational path from `out_ready` to `out_data`.

## Test plan
- Basic frame: write "Hello World" (0x48 0x65 0x6C 0x6C 0x6F 0x20 0x57 0x6F 0x72 0x6C 0x64) at addresses 0..10, SEQ_EN=1, `len`=11, `out_ready`=1 → beats 0x00 0x00 then the 11 bytes. `out_last` only on 0x64. `done` on the next cycle. `seq_num` becomes 1.
- Backpressure: the same frame with `out_ready` toggled pseudo-randomly → an identical byte sequence; `out_data`/`out_last` stable whenever `out_valid`=1 and `out_ready`=0.
- Boundaries:
  - `len`=0 → no activity.
  - `len`=1 with SEQ_EN=0 → a single beat with `out_last`=1.
  - `len`=DEPTH+5 → exactly DEPTH payload bytes.
- Sequence wrap: run 65537 frames, or force the counter to 0xFFFF → the frame header is 0xFF 0xFF, and the next frame's header is 0x00 0x00.
- Ignored inputs during a frame: `start`, and `wr_en` writing 0xAA to address 0, while `busy`=1 → no restart; the current and next frames both still read the original address-0 byte.
- Reset mid-frame: assert `rst` during beat 5 → `out_valid`=0 and `busy`=0 immediately and `seq_num`=0. A following `start` produces a complete, correct frame.

Source files
------------

// File: rtl/udp_payload_streamer.sv
`default_nettype none
// ============================================================================
// Module   : udp_payload_streamer
// Purpose  : Byte-stream payload source. The host loads a payload buffer;
//            on an accepted start one frame of len bytes is streamed out
//            over valid/ready, optionally prefixed by a 16-bit big-endian
//            sequence number. out_last flags the final beat and done pulses
//            for one cycle once that beat has transferred.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            wr_en/addr/data    - payload buffer write port (idle only)
//            start, len         - frame request and payload length
//            out_data/valid/last, out_ready - output byte stream
//            busy, done         - frame in progress / frame finished pulse
//            seq_num            - sequence number of next/current frame
// Revision : 1.0 - initial release
// ============================================================================
module udp_payload_streamer #(
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH),
    parameter int LW     = $clog2(DEPTH) + 1,
    parameter int SEQ_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [15:0]   seq_num
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEQ_HI = 3'd1,
        S_SEQ_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [LW-1:0] c_max_len     = LW'(DEPTH);
    localparam state_t        c_first_state = (SEQ_EN != 0) ? S_SEQ_HI : S_DATA;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [15:0]   seq_q, seq_d;
    logic [7:0]    mem_q [DEPTH];

    logic          w_start_acc;
    logic          w_wr_ok;
    logic          w_hs;
    logic          w_last_beat;
    logic [LW-1:0] w_len_clamped;

    // DONE is not busy, so a new frame may be accepted there.
    assign w_start_acc   = start && (len != '0) &&
                           ((state_q == S_IDLE) || (state_q == S_DONE));
    // Writes are blocked in the accept cycle so the frame payload is frozen.
    assign w_wr_ok       = wr_en && !busy && !w_start_acc;
    assign w_hs          = out_valid && out_ready;
    assign w_last_beat   = (LW'(rd_ptr_q) == (len_q - LW'(1)));
    assign w_len_clamped = (len > c_max_len) ? c_max_len : len;
    assign seq_num       = seq_q;

    // Payload buffer: no reset, contents undefined until written.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            len_q    <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            seq_q    <= seq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        seq_d    = seq_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // The counter advances on leaving DONE, so a frame started
                // straight from DONE already carries the new number.
                if (state_q == S_DONE) begin
                    seq_d = seq_q + 16'd1;
                end
                if (w_start_acc) begin
                    len_d    = w_len_clamped;
                    rd_ptr_d = '0;
                    state_d  = c_first_state;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEQ_HI: begin
                if (w_hs) begin
                    state_d = S_SEQ_LO;
                end
            end
            S_SEQ_LO: begin
                if (w_hs) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (w_last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; out_ready never reaches out_data.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_SEQ_HI: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = seq_q[15:8];
            end
            S_SEQ_LO: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = seq_q[7:0];
            end
            S_DATA: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = mem_q[rd_ptr_q];
                out_last  = w_last_beat;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_payload_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_payload_streamer
// Purpose  : Self-checking bench for udp_payload_streamer. Instance 0 has the
//            sequence prefix enabled, instance 1 streams payload only.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_payload_streamer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int inst;
        int len;
        bit bp;
        int exp_beats;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [1:0]    start;
    logic [LW-1:0] len;
    logic          out_ready;
    logic [7:0]    od  [2];
    logic          ov  [2];
    logic          ol  [2];
    logic          bsy [2];
    logic          dn  [2];
    logic [15:0]   sq  [2];

    always #5 clk = ~clk;

    udp_payload_streamer #(.DEPTH(DEPTH), .SEQ_EN(1)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start[0]), .len(len),
        .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
        .out_ready(out_ready), .busy(bsy[0]), .done(dn[0]), .seq_num(sq[0])
    );

    udp_payload_streamer #(.DEPTH(DEPTH), .SEQ_EN(0)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start[1]), .len(len),
        .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
        .out_ready(out_ready), .busy(bsy[1]), .done(dn[1]), .seq_num(sq[1])
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem_m [DEPTH];
    logic [15:0] seq_m [2];
    beat_t       q0[$];
    beat_t       q1[$];
    int          beats [2];
    int          beats_at_issue [2];
    bit          pend_done [2];
    bit          stall_v [2];
    logic [7:0]  stall_d [2];
    logic        stall_l [2];
    bit          bp_en = 1'b0;
    logic [7:0]  hello [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ready driver: changes at posedge+2 so the main thread's bp_en update
    // at posedge+1 is always seen in the same cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor: pops expected beats on each handshake, checks
    // stall stability and the done pulse after the last beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    pend_done[k] = 1'b0;
                    stall_v[k]   = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (stall_v[k]) begin
                        chk("hold_valid", 32'(ov[k]), 32'd1);
                        chk("hold_data", 32'(od[k]), 32'(stall_d[k]));
                        chk("hold_last", 32'(ol[k]), 32'(stall_l[k]));
                    end
                    if (pend_done[k]) begin
                        chk("done_pulse", 32'(dn[k]), 32'd1);
                        chk("done_valid_low", 32'(ov[k]), 32'd0);
                        chk("done_busy_low", 32'(bsy[k]), 32'd0);
                        pend_done[k] = 1'b0;
                    end else if (dn[k]) begin
                        chk("stray_done", 32'(dn[k]), 32'd0);
                    end
                    if (ov[k] && out_ready) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat inst%0d: got %02h, expected no beat", k, od[k]);
                        end else begin
                            if (k == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk("beat_data", 32'(od[k]), 32'(e.d));
                            chk("beat_last", 32'(ol[k]), 32'(e.l));
                        end
                        beats[k]++;
                        if (ol[k]) pend_done[k] = 1'b1;
                    end
                    stall_v[k] = ov[k] && !out_ready;
                    stall_d[k] = od[k];
                    stall_l[k] = ol[k];
                end
            end
        end
    end

    task automatic wr_byte(input int a, input logic [7:0] d, input logic [1:0] en, input bit apply);
        wr_en   = en;
        wr_addr = AW'(a);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 2'b00;
        if (apply) mem_m[a] = d;
    endtask

    task automatic push_frame(input int k, input int l);
        int    n = (l > DEPTH) ? DEPTH : l;
        beat_t b;
        if (k == 0) begin
            b.d = seq_m[0][15:8]; b.l = 1'b0; q0.push_back(b);
            b.d = seq_m[0][7:0];  b.l = 1'b0; q0.push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            b.d = mem_m[i];
            b.l = (i == n - 1);
            if (k == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic issue(input int k, input int l);
        start[k]          = 1'b1;
        len               = LW'(l);
        beats_at_issue[k] = beats[k];
        if (l != 0) push_frame(k, l);
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        if (l != 0) begin
            chk("busy_on_start", 32'(bsy[k]), 32'd1);
            chk("valid_on_start", 32'(ov[k]), 32'd1);
        end
    endtask

    task automatic finish_frame(input int k, input int exp_beats, input bit chk_lat);
        int cyc = 0;
        bit got = 1'b0;
        while (!got && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (dn[k]) got = 1'b1;
        end
        chk("frame_done_seen", 32'(got), 32'd1);
        if (chk_lat) chk("frame_latency", 32'(cyc), 32'(exp_beats + 1));
        @(posedge clk);
        #1;
        seq_m[k] = seq_m[k] + 16'd1;
        chk("seq_num", 32'(sq[k]), 32'(seq_m[k]));
        chk("beat_count", 32'(beats[k] - beats_at_issue[k]), 32'(exp_beats));
        chk("queue_drained", 32'(k == 0 ? q0.size() : q1.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs [8];
        rst       = 1'b1;
        wr_en     = 2'b00;
        wr_addr   = '0;
        wr_data   = 8'h00;
        start     = 2'b00;
        len       = '0;
        for (int k = 0; k < 2; k++) begin
            seq_m[k] = 16'h0000;
            beats[k] = 0;
            beats_at_issue[k] = 0;
        end
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                  8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
        //          inst len bp beats
        vecs[0] = '{0, 11, 1'b0, 13};
        vecs[1] = '{0, 11, 1'b1, 13};
        vecs[2] = '{0,  1, 1'b0,  3};
        vecs[3] = '{0, 16, 1'b0, 18};
        vecs[4] = '{0, 21, 1'b0, 18};
        vecs[5] = '{1,  1, 1'b0,  1};
        vecs[6] = '{1, 11, 1'b1, 11};
        vecs[7] = '{1, 21, 1'b0, 16};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_data", 32'(od[k]), 32'd0);
            chk("reset_out_valid", 32'(ov[k]), 32'd0);
            chk("reset_out_last", 32'(ol[k]), 32'd0);
            chk("reset_busy", 32'(bsy[k]), 32'd0);
            chk("reset_done", 32'(dn[k]), 32'd0);
            chk("reset_seq_num", 32'(sq[k]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            if (i < 11) wr_byte(i, hello[i], 2'b11, 1'b1);
            else        wr_byte(i, 8'(8'hC0 + i), 2'b11, 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            bp_en = vecs[i].bp;
            issue(vecs[i].inst, vecs[i].len);
            finish_frame(vecs[i].inst, vecs[i].exp_beats, !vecs[i].bp);
            bp_en = 1'b0;
        end

        // len = 0 is ignored entirely.
        issue(0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("len0_busy", 32'(bsy[0]), 32'd0);
        chk("len0_valid", 32'(ov[0]), 32'd0);
        chk("len0_seq", 32'(sq[0]), 32'(seq_m[0]));

        // start and a buffer write during a frame are both ignored.
        issue(0, 11);
        fork
            finish_frame(0, 13, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                start[0] = 1'b1;
                len      = LW'(4);
                wr_en    = 2'b01;
                wr_addr  = '0;
                wr_data  = 8'hAA;
                @(posedge clk);
                #1;
                start[0] = 1'b0;
                wr_en    = 2'b00;
            end
        join
        issue(0, 2);
        finish_frame(0, 4, 1'b1);

        // A write in the same cycle a start is accepted is dropped.
        wr_en   = 2'b01;
        wr_addr = AW'(1);
        wr_data = 8'h55;
        issue(0, 2);
        wr_en = 2'b00;
        finish_frame(0, 4, 1'b1);
        issue(0, 2);
        finish_frame(0, 4, 1'b1);

        // Sequence wrap: header FF FF, then 00 00.
        force dut0.seq_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut0.seq_q;
        seq_m[0] = 16'hFFFF;
        issue(0, 3);
        finish_frame(0, 5, 1'b1);
        issue(0, 3);
        finish_frame(0, 5, 1'b1);

        // Reset during beat 5, then a clean frame.
        issue(0, 11);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        chk("midrst_busy", 32'(bsy[0]), 32'd0);
        chk("midrst_last", 32'(ol[0]), 32'd0);
        chk("midrst_seq", 32'(sq[0]), 32'd0);
        q0.delete();
        seq_m[0] = 16'h0000;
        seq_m[1] = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 11);
        finish_frame(0, 13, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
